// File: rtl/mux_nw_reg_if.sv
// ---------------------------------------------------------------------------
// mux_nw_reg_if
// Bundle of the producer-side and consumer-side signals of mux_nw_reg.
//   d      : N*W packed channel data, channel i at [i*W +: W]
//   d_vld  : per-channel data valid (source holds data until d_ack)
//   d_ack  : one-hot capture acknowledge (combinational from the mux)
//   s      : channel select used in DIRECT mode
//   mode   : 00 DIRECT, 01 SCAN, 10 RR, 11 behaves as DIRECT
//   y      : registered output word
//   y_ch   : channel index that produced y
//   y_vld  : y / y_ch hold valid data
//   y_rdy  : downstream consumer accepts y this cycle
// Modports:
//   slave  : the mux itself
//   master : the environment (producers + consumer)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface mux_nw_reg_if #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = 3
);
  logic [N*W-1:0] d;
  logic [N-1:0]   d_vld;
  logic [N-1:0]   d_ack;
  logic [SW-1:0]  s;
  logic [1:0]     mode;
  logic [W-1:0]   y;
  logic [SW-1:0]  y_ch;
  logic           y_vld;
  logic           y_rdy;

  modport slave (
    input  d, d_vld, s, mode, y_rdy,
    output d_ack, y, y_ch, y_vld
  );

  modport master (
    output d, d_vld, s, mode, y_rdy,
    input  d_ack, y, y_ch, y_vld
  );
endinterface

// File: rtl/mux_nw_reg.sv
// ---------------------------------------------------------------------------
// mux_nw_reg
// Registered N-channel, W-bit multiplexer with a per-channel valid/ack input
// handshake and a valid/ready output stage. The channel to capture is chosen
// by one of three modes: DIRECT (select input), SCAN (free-running pointer)
// and RR (round-robin over channels presenting valid data).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; clears the output stage and the
//          pointer and forces d_ack low while asserted
//   bus  : mux_nw_reg_if.slave carrying d/d_vld/d_ack/s/mode/y/y_ch/y_vld/y_rdy
// Parameters: N channels (>= 2), W bits per channel, SW = clog2(N).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mux_nw_reg #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  mux_nw_reg_if.slave   bus
);

  localparam logic [1:0]    MODE_SCAN = 2'b01;
  localparam logic [1:0]    MODE_RR   = 2'b10;
  localparam logic [SW-1:0] LAST_CH   = SW'(N - 1);
  localparam logic [SW:0]   N_EXT     = (SW + 1)'(N);

  // Registered state
  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_y;
  logic [SW-1:0] r_y_ch;
  logic          r_y_vld;

  // Combinational helpers
  logic          w_open;
  logic [N-1:0]  w_rot;
  logic [SW-1:0] w_cand;
  logic          w_has_cand;
  logic          w_cand_vld;
  logic [W-1:0]  w_cand_data;
  logic          w_cap;
  logic [N-1:0]  w_ack;
  logic [SW-1:0] w_ptr_inc;
  logic [SW-1:0] w_cand_inc;
  logic [SW-1:0] w_ptr_nxt;

  // Output slot can take a new word when empty or being drained this cycle.
  assign w_open = ~r_y_vld | bus.y_rdy;

  // Valid bits rotated so that bit k is channel (ptr + k) mod N. Doubling the
  // vector keeps the rotation correct for non-power-of-2 N since ptr < N.
  assign w_rot = N'({bus.d_vld, bus.d_vld} >> r_ptr);

  // Candidate channel selection for the current mode.
  always_comb begin
    logic [SW:0] v_sum;
    w_cand     = {SW{1'b0}};
    w_has_cand = 1'b0;
    v_sum      = {(SW+1){1'b0}};
    case (bus.mode)
      MODE_SCAN: begin
        w_cand     = r_ptr;
        w_has_cand = 1'b1;
      end
      MODE_RR: begin
        // Walk from the far end back to ptr so the nearest valid channel in
        // circular order is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
          v_sum = {1'b0, r_ptr} + (SW + 1)'(k);
          if (v_sum >= N_EXT) begin
            v_sum = v_sum - N_EXT;
          end else begin
            v_sum = v_sum;
          end
          if (w_rot[k]) begin
            w_cand     = v_sum[SW-1:0];
            w_has_cand = 1'b1;
          end else begin
            w_cand     = w_cand;
            w_has_cand = w_has_cand;
          end
        end
      end
      default: begin
        // DIRECT and the reserved encoding: out-of-range selects never capture.
        w_cand     = bus.s;
        w_has_cand = ({1'b0, bus.s} < N_EXT);
      end
    endcase
  end

  // Gather the candidate's valid bit and data word with an AND-OR mux.
  always_comb begin
    w_cand_vld  = 1'b0;
    w_cand_data = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_cand_vld  = w_cand_vld  | (bus.d_vld[i] & (w_cand == SW'(i)));
      w_cand_data = w_cand_data | (bus.d[i*W +: W] & {W{w_cand == SW'(i)}});
    end
  end

  assign w_cap = w_open & w_has_cand & w_cand_vld;

  // One-hot acknowledge of the captured channel, suppressed during reset.
  always_comb begin
    w_ack = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_ack[i] = w_cap & ~rst & (w_cand == SW'(i));
    end
  end

  assign bus.d_ack = w_ack;

  // Explicit wrap at N-1 so non-power-of-2 channel counts stay in range.
  assign w_ptr_inc  = (r_ptr  == LAST_CH) ? {SW{1'b0}} : r_ptr  + SW'(1);
  assign w_cand_inc = (w_cand == LAST_CH) ? {SW{1'b0}} : w_cand + SW'(1);

  // Pointer next state for the active mode.
  always_comb begin
    w_ptr_nxt = r_ptr;
    case (bus.mode)
      MODE_SCAN: begin
        if (w_open) begin
          w_ptr_nxt = w_ptr_inc;
        end else begin
          w_ptr_nxt = r_ptr;
        end
      end
      MODE_RR: begin
        if (w_cap) begin
          w_ptr_nxt = w_cand_inc;
        end else begin
          w_ptr_nxt = r_ptr;
        end
      end
      default: begin
        w_ptr_nxt = r_ptr;
      end
    endcase
  end

  // Pointer and output stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= {SW{1'b0}};
      r_y     <= {W{1'b0}};
      r_y_ch  <= {SW{1'b0}};
      r_y_vld <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_cap) begin
        r_y     <= w_cand_data;
        r_y_ch  <= w_cand;
        r_y_vld <= 1'b1;
      end else if (w_open) begin
        r_y_vld <= 1'b0;
      end else begin
        r_y_vld <= r_y_vld;
      end
    end
  end

  assign bus.y     = r_y;
  assign bus.y_ch  = r_y_ch;
  assign bus.y_vld = r_y_vld;

endmodule

// File: tb/tb_mux_nw_reg.sv
`timescale 1ns/1ps
module tb_mux_nw_reg;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_nw_reg_if #(.N(N), .W(W), .SW(SW)) bus8 ();
  mux_nw_reg_if #(.N(5), .W(W), .SW(SW)) bus5 ();

  mux_nw_reg #(.N(N), .W(W), .SW(SW)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  mux_nw_reg #(.N(5), .W(W), .SW(SW)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [W-1:0]  data;
  } word_t;

  word_t        sb[$];
  int           ch_log[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           mon_en  = 1'b0;
  bit           m_vld   = 1'b0;
  int           m_ptr   = 0;
  logic [N-1:0] last_ack = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_len"}, 64'(ch_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < ch_log.size(); i++) begin
      chk(name, 64'(ch_log[i]), 64'(exp[i]));
    end
  endtask

  // Reference model: one cycle of the mux derived directly from its rules.
  // Called at posedge+1 with inputs set; ends at the next posedge+1.
  task automatic tick();
    int           c;
    int           nptr;
    bit           has, open, cap, nvld;
    logic [N-1:0] e_ack;
    word_t        w;
    #2;
    open = !m_vld || bus8.y_rdy;
    has  = 1'b0;
    c    = 0;
    case (bus8.mode)
      2'b01: begin c = m_ptr; has = 1'b1; end
      2'b10: begin
        for (int k = 0; k < N; k++) begin
          if (!has && bus8.d_vld[(m_ptr + k) % N]) begin
            c   = (m_ptr + k) % N;
            has = 1'b1;
          end
        end
      end
      default: begin c = int'(bus8.s); has = (c < N); end
    endcase
    cap   = open && has && bus8.d_vld[c];
    e_ack = '0;
    if (cap) e_ack[c] = 1'b1;
    chk("d_ack", 64'(bus8.d_ack), 64'(e_ack));
    if (cap) begin
      w.ch   = SW'(c);
      w.data = bus8.d[c*W +: W];
      sb.push_back(w);
    end
    nvld = cap ? 1'b1 : (open ? 1'b0 : m_vld);
    case (bus8.mode)
      2'b01:   nptr = open ? (m_ptr + 1) % N : m_ptr;
      2'b10:   nptr = cap ? (c + 1) % N : m_ptr;
      default: nptr = m_ptr;
    endcase
    last_ack = e_ack;
    @(posedge clk);
    #1;
    m_vld = nvld;
    m_ptr = nptr;
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_y_vld", 64'(bus8.y_vld), 64'd0);
    chk("rst_y",     64'(bus8.y),     64'd0);
    chk("rst_y_ch",  64'(bus8.y_ch),  64'd0);
    chk("rst_d_ack", 64'(bus8.d_ack), 64'd0);
    sb.delete();
    m_vld    = 1'b0;
    m_ptr    = 0;
    last_ack = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ch_log.delete();
  endtask

  task automatic drain();
    bus8.mode  = 2'b00;
    bus8.s     = 3'd0;
    bus8.d_vld = '0;
    bus8.y_rdy = 1'b1;
    tick();
    tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands a word downstream.
  always @(negedge clk) begin : monitor
    word_t w;
    if (mon_en && !rst) begin
      chk("y_vld", 64'(bus8.y_vld), 64'(m_vld));
      if (bus8.y_vld && bus8.y_rdy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          w = sb.pop_front();
          chk("y",    64'(bus8.y),    64'(w.data));
          chk("y_ch", 64'(bus8.y_ch), 64'(w.ch));
        end
        ch_log.push_back(int'(bus8.y_ch));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus8.d = '0; bus8.d_vld = 8'hFF; bus8.s = 3'd0; bus8.mode = 2'b00; bus8.y_rdy = 1'b1;
    bus5.d = '0; bus5.d_vld = '0;    bus5.s = 3'd0; bus5.mode = 2'b00; bus5.y_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a would-be capture held off by rst.
    chk("init_y_vld", 64'(bus8.y_vld), 64'd0);
    chk("init_y",     64'(bus8.y),     64'd0);
    chk("init_y_ch",  64'(bus8.y_ch),  64'd0);
    chk("init_d_ack", 64'(bus8.d_ack), 64'd0);
    bus8.d_vld = '0;
    rst    = 1'b0;
    mon_en = 1'b1;

    // DIRECT capture of channel 3.
    bus8.d[3*W +: W] = 8'hA5;
    bus8.d_vld = 8'h08; bus8.s = 3'd3; bus8.mode = 2'b00; bus8.y_rdy = 1'b1;
    tick();
    chk("direct_y",     64'(bus8.y),     64'hA5);
    chk("direct_y_ch",  64'(bus8.y_ch),  64'd3);
    chk("direct_y_vld", 64'(bus8.y_vld), 64'd1);
    bus8.s = 3'd5;
    tick();
    chk("direct_novld", 64'(bus8.y_vld), 64'd0);

    // Backpressure: four held cycles then a no-bubble reload.
    for (int i = 0; i < N; i++) bus8.d[i*W +: W] = 8'(8'h30 + i);
    bus8.d_vld = 8'hFF; bus8.s = 3'd3; bus8.y_rdy = 1'b1;
    tick();
    bus8.y_rdy = 1'b0;
    repeat (4) begin
      tick();
      chk("bp_y",     64'(bus8.y),     64'h33);
      chk("bp_y_vld", 64'(bus8.y_vld), 64'd1);
    end
    bus8.s = 3'd6; bus8.y_rdy = 1'b1;
    tick();
    chk("bp_reload_y",   64'(bus8.y),     64'h36);
    chk("bp_reload_vld", 64'(bus8.y_vld), 64'd1);

    // Reset while a word is held.
    bus8.y_rdy = 1'b0;
    tick();
    chk("pre_rst_vld", 64'(bus8.y_vld), 64'd1);
    do_reset();

    // SCAN with all channels valid.
    for (int i = 0; i < N; i++) bus8.d[i*W +: W] = 8'(i);
    bus8.d_vld = 8'hFF; bus8.mode = 2'b01; bus8.y_rdy = 1'b1;
    repeat (10) tick();
    drain();
    chk_log("scan_ff", '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1});

    // SCAN with only channels 0 and 2 valid.
    do_reset();
    bus8.d_vld = 8'h05; bus8.mode = 2'b01;
    repeat (8) tick();
    drain();
    chk_log("scan_05", '{0, 2});

    // Round-robin, then with channel 4 withdrawn.
    do_reset();
    bus8.d_vld = 8'h91; bus8.mode = 2'b10;
    repeat (6) tick();
    bus8.d_vld = 8'h81;
    repeat (4) tick();
    drain();
    chk_log("rr", '{0, 4, 7, 0, 4, 7, 0, 7, 0, 7});

    // Randomised traffic; sources hold data until acknowledged.
    do_reset();
    last_ack = '0;
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      if (it % 8 == 0) bus8.mode = 2'($urandom_range(0, 3));
      bus8.s     = 3'($urandom_range(0, 7));
      bus8.y_rdy = ($urandom_range(0, 9) < 7);
      for (int j = 0; j < N; j++) begin
        if (last_ack[j] || !bus8.d_vld[j]) begin
          bus8.d_vld[j]    = 1'($urandom_range(0, 1));
          bus8.d[j*W +: W] = 8'($urandom);
        end
      end
      tick();
    end
    drain();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Non-power-of-2 instance: SCAN wraps 4 -> 0.
    do_reset();
    for (int i = 0; i < 5; i++) bus5.d[i*W +: W] = 8'(8'h10 + i);
    bus5.d_vld = 5'h1F; bus5.mode = 2'b01; bus5.y_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("n5_scan_ch",  64'(bus5.y_ch),  64'(i % 5));
      chk("n5_scan_y",   64'(bus5.y),     64'(8'h10 + (i % 5)));
      chk("n5_scan_vld", 64'(bus5.y_vld), 64'd1);
    end
    // DIRECT with an out-of-range select never captures.
    bus5.mode = 2'b00; bus5.s = 3'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("n5_s6_ack", 64'(bus5.d_ack), 64'd0);
      @(posedge clk);
      #1;
      chk("n5_s6_vld", 64'(bus5.y_vld), 64'd0);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_nw_reg.md
Name: mux_nw_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Generalises the 8:1 single-bit combinational mux to N channels of W bits each.
- Adds per-channel valid/ack input handshake, a valid/ready output stage, and three channel-selection modes: direct select, auto-scan, and round-robin.
- Sits between multiple producers and a single downstream consumer. Typical uses are a shared bus or a serial output path.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 8, data width per channel in bits (W >= 1).
- SW, 3, select/pointer width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
- d_vld  input  N  per-channel data valid; a source holds its data stable until it sees d_ack.
- d_ack  output  N  one-hot, combinational; bit i high in the cycle channel i is captured.
- s  input  SW  channel select, used in DIRECT mode only.
- mode  input  2  00 DIRECT, 01 SCAN, 10 RR, 11 reserved (behaves as DIRECT).
- y  output  W  registered output data.
- y_ch  output  SW  index of the channel that produced y.
- y_vld  output  1  y/y_ch hold valid data.
- y_rdy  input  1  consumer accepts y this cycle.

Behaviour:
- Reset, asynchronous and immediate:
  - y = 0, y_ch = 0, y_vld = 0, internal pointer ptr = 0.
  - d_ack forced to 0 while rst is high.
  - Any data in flight is dropped.
- Load slot open: open = !y_vld || y_rdy.
- Candidate channel c, combinational, by mode:
  - DIRECT: c = s. If s >= N, there is no candidate.
  - SCAN: c = ptr.
  - RR: c = first index j in circular order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with d_vld[j] = 1. If no d_vld bit is set, there is no candidate.
- Capture: when open and a candidate exists with d_vld[c] = 1:
  - d_ack[c] = 1 in that cycle.
  - At the next rising edge: y <= d[c], y_ch <= c, y_vld <= 1.
- No capture while open: y_vld <= 0 at the next edge. y and y_ch hold their last values.
- Hold: y_vld && !y_rdy holds y, y_ch and y_vld. d_ack stays all-zero (backpressure).
- Latency: 1 cycle from capture to y_vld. Throughput: 1 word per cycle while y_rdy = 1.
- Pointer update:
  - SCAN: ptr advances by 1 every cycle the slot is open, captured or not. Wrap N-1 -> 0 (also correct for non-power-of-2 N).
  - RR: on capture, ptr <= (c+1) mod N. Otherwise ptr holds.
  - DIRECT: ptr holds.
- Mode change takes effect in the same cycle as the mode input changes. ptr is retained across mode changes and is not reset.
- Simultaneous events:
  - A capture and an output handshake in the same cycle: the old word is accepted and the new word is loaded, with no bubble.
  - Several d_vld bits set: only one channel is acked per cycle. The other channels keep their d_vld asserted.
- Reset mid-transfer: the output word is lost and y_vld drops asynchronously. Sources holding d_vld retry after reset.

Test Plan:
- Reset: assert rst mid-stream with y_vld = 1 -> y_vld = 0, y = 0, y_ch = 0 and d_ack = 0 immediately, before the next clock edge.
- DIRECT: N=8, W=8, d[ch3] = 0xA5, d_vld = 0x08, s = 3, y_rdy = 1 -> d_ack = 0x08 in cycle t, then y = 0xA5, y_ch = 3, y_vld = 1 in cycle t+1. With s = 5 and d_vld[5] = 0 -> no ack, and y_vld falls.
- Backpressure: y_vld = 1, y_rdy = 0 for 4 cycles, d_vld = 0xFF -> d_ack = 0 and y held for 4 cycles. Then y_rdy = 1 -> next word loads with no bubble.
- SCAN: d_vld = 0xFF, d[i] = i, y_rdy = 1 -> y_ch sequence 0,1,...,7,0,1 on consecutive cycles. Repeat with d_vld = 0x05 -> outputs only from channels 0 and 2, with y_vld low in the cycles when ptr is at 1 and 3..7.
- RR: d_vld = 0x91 held, y_rdy = 1 -> y_ch sequence 0,4,7,0,4,7. Then deassert d_vld[4] -> sequence 0,7,0,7.
- Wrap and non-power-of-2: N=5, SW=3, SCAN mode -> ptr sequence 0,1,2,3,4,0. DIRECT mode with s = 6 -> never acks, y_vld = 0.
